// File: rtl/checker_parallax_pkg.sv
// checker_pkg: shared constants and helpers for the parallax checkerboard renderer.
//   RGB_W       : width of an RGB222 pixel {R[1:0],G[1:0],B[1:0]}
//   COL_RED_HI  : colour of layer 2
//   COL_RED_LO  : colour of layers 3 and above
//   GREY_XOR    : mask applied to fg_color to derive the layer-1 colour
//   layer_color : colour of layer idx, given the foreground colour
package checker_pkg;

  localparam int RGB_W = 6;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t COL_RED_HI = 6'b10_00_00;
  localparam rgb_t COL_RED_LO = 6'b01_00_00;
  localparam rgb_t GREY_XOR   = 6'b00_10_10;

  function automatic rgb_t layer_color(input int idx, input rgb_t fg);
    rgb_t col;
    case (idx)
      0:       col = fg;
      1:       col = fg ^ GREY_XOR;
      2:       col = COL_RED_HI;
      default: col = COL_RED_LO;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/checker_parallax_layer.sv
// checker_layer: combinational hit test for one scrolling checkerboard layer.
// The layer is offset by the frame counter (faster horizontal scroll for the
// front layers, slower vertical scroll for the back ones). Its square size
// halves with each step toward the back.
// Ports:
//   hpos, vpos : beam position
//   frame      : animation frame counter
//   hit        : 1 when this layer is lit at the current beam position
// Build option: CHECKER_DITHER_EN gates layers 0, 1 and the rearmost layer
// (when its index is 2 or more) with stipple patterns.
module checker_layer
  import checker_pkg::*;
#(
  parameter int IDX        = 0,
  parameter int NUM_LAYERS = 5,
  parameter int COORD_W    = 10,
  parameter int COUNTER_W  = 10
) (
  input  logic [COORD_W-1:0]   hpos,
  input  logic [COORD_W-1:0]   vpos,
  input  logic [COUNTER_W-1:0] frame,
  output logic                 hit
);

  // The arithmetic is done wide enough to hold the full counter.
  // Shifting right therefore sees the counter bits above COORD_W before the result is truncated.
  localparam int EXT_W   = (COORD_W > COUNTER_W) ? COORD_W : COUNTER_W;
  localparam int SHL     = NUM_LAYERS - 1 - IDX;
  localparam int BIT_RAW = COORD_W - 2 - IDX;
  localparam int BIT_SEL = (BIT_RAW < 0) ? 0 : BIT_RAW;
  localparam logic [EXT_W-1:0] BIT_MASK = EXT_W'(1) << BIT_SEL;

  logic [EXT_W-1:0] frame_ext;
  logic [EXT_W-1:0] x_full;
  logic [EXT_W-1:0] y_full;
  logic             solid_hit;

  assign frame_ext = EXT_W'(frame);
  assign x_full    = EXT_W'(hpos) + (frame_ext << SHL);
  assign y_full    = EXT_W'(vpos) + (frame_ext >> IDX);

  // BIT_SEL is below COORD_W, so bits above the coordinate width never reach the result.
  // Truncating to COORD_W is therefore implicit.
  assign solid_hit = ^((x_full ^ y_full) & BIT_MASK);

`ifdef CHECKER_DITHER_EN
  logic gate;
  generate
    if (IDX == 0) begin : g_gate_front
      assign gate = vpos[1] ^ hpos[0];
    end else if (IDX == 1) begin : g_gate_second
      assign gate = (~vpos[0]) ^ hpos[1];
    end else if (IDX == NUM_LAYERS - 1) begin : g_gate_rear
      assign gate = vpos[1] ^ hpos[0];
    end else begin : g_gate_none
      assign gate = 1'b1;
    end
  endgenerate
  assign hit = solid_hit & gate;
`else
  assign hit = solid_hit;
`endif

endmodule

// File: rtl/checker_parallax.sv
// checker_parallax: parallax checkerboard renderer placed between the sync
// generator and the RGB222 output mapping.
// Ports:
//   clk, reset            : pixel clock, synchronous active-high reset
//   hpos, vpos            : beam position
//   display_on            : visible-area flag
//   hsync_in, vsync_in    : syncs from the generator
//   run, step, dir        : animation control (free run, single step, reverse)
//   fg_color              : RGB222 colour of the front layer
//   rgb                   : registered pixel, two clocks after hpos/vpos
//   hsync_out, vsync_out  : syncs delayed to line up with rgb
//   frame                 : animation frame counter
// Build option: CHECKER_DITHER_EN enables stipple gating inside checker_layer.
// Latency is the same in both builds.
module checker_parallax
  import checker_pkg::*;
#(
  parameter int NUM_LAYERS = 5,
  parameter int COORD_W    = 10,
  parameter int COUNTER_W  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   hpos,
  input  logic [COORD_W-1:0]   vpos,
  input  logic                 display_on,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 run,
  input  logic                 step,
  input  logic                 dir,
  input  logic [RGB_W-1:0]     fg_color,
  output logic [RGB_W-1:0]     rgb,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic [COUNTER_W-1:0] frame
);

  // Frame counter and step state
  logic [COUNTER_W-1:0] frame_q, frame_d;
  logic                 vsync_q;
  logic                 seen_low_q;
  logic                 step_pending_q, step_pending_d;
  logic                 frame_edge;
  logic                 step_req;
  logic                 advance;

  // Pipeline stage 1
  logic [NUM_LAYERS-1:0] hit_w;
  logic [NUM_LAYERS-1:0] hit_q;
  logic                  disp_q;
  logic                  hsync_q;
  rgb_t                  fg_q;

  // Pipeline stage 2
  rgb_t rgb_q, rgb_d;
  logic hsync_out_q;
  logic vsync_out_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      checker_layer #(
        .IDX        (gi),
        .NUM_LAYERS (NUM_LAYERS),
        .COORD_W    (COORD_W),
        .COUNTER_W  (COUNTER_W)
      ) u_layer (
        .hpos  (hpos),
        .vpos  (vpos),
        .frame (frame_q),
        .hit   (hit_w[gi])
      );
    end
  endgenerate

  // vsync_q is cleared by reset and does not hold a real sample afterwards.
  // An edge is counted only once vsync_in has been seen low after reset.
  // This way a vsync that is already high at reset release is not counted.
  assign frame_edge = vsync_in & ~vsync_q & seen_low_q;
  assign step_req   = step & ~run;
  assign advance    = frame_edge & (run | step_pending_q | step_req);

  always_comb begin
    frame_d = frame_q;
    if (advance) begin
      frame_d = dir ? (frame_q - COUNTER_W'(1)) : (frame_q + COUNTER_W'(1));
    end
    // Every frame edge consumes a pending step, including a step that arrives on the edge itself.
    step_pending_d = frame_edge ? 1'b0 : (step_pending_q | step_req);
  end

  // Priority mux: walk from the rearmost layer forward so the lowest-index hit wins.
  always_comb begin
    rgb_d = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        rgb_d = layer_color(i, fg_q);
      end
    end
    if (!disp_q) begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q        <= '0;
      vsync_q        <= 1'b0;
      seen_low_q     <= 1'b0;
      step_pending_q <= 1'b0;
      hit_q          <= '0;
      disp_q         <= 1'b0;
      hsync_q        <= 1'b0;
      fg_q           <= '0;
      rgb_q          <= '0;
      hsync_out_q    <= 1'b0;
      vsync_out_q    <= 1'b0;
    end else begin
      frame_q        <= frame_d;
      vsync_q        <= vsync_in;  // doubles as the stage-1 vsync delay
      seen_low_q     <= seen_low_q | ~vsync_in;
      step_pending_q <= step_pending_d;
      hit_q          <= hit_w;
      disp_q         <= display_on;
      hsync_q        <= hsync_in;
      fg_q           <= fg_color;
      rgb_q          <= rgb_d;
      hsync_out_q    <= hsync_q;
      vsync_out_q    <= vsync_q;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;
  assign frame     = frame_q;

endmodule

// File: doc/checker_parallax.md
# checker_parallax

Parametrised parallax checkerboard renderer: draws `NUM_LAYERS` scrolling checkerboard layers with a fixed priority order and per-layer scroll speed, driven by the beam position from `hvsync_generator`. It sits between the sync generator and the TinyVGA PMOD output mapping. It adds run/pause/single-step and reverse control over the animation frame counter. It also adds a registered, latency-matched RGB/sync output path.

## Interface
Parameters:
- `NUM_LAYERS`, 5: number of checker layers, 1..8; layer 0 is frontmost.
- `COORD_W`, 10: width of `hpos`/`vpos` and of the offset arithmetic.
- `COUNTER_W`, 10: width of the frame counter.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `hpos`  in  COORD_W  beam x from sync generator.
- `vpos`  in  COORD_W  beam y.
- `display_on`  in  1  visible-area flag.
- `hsync_in`  in  1  hsync from sync generator.
- `vsync_in`  in  1  vsync from sync generator.
- `run`  in  1  1 = advance the counter every frame.
- `step`  in  1  one-cycle pulse; while `run`=0, advance the counter exactly one frame.
- `dir`  in  1  0 = counter increments, 1 = counter decrements.
- `fg_color`  in  6  RGB222 colour {R,G,B} for layer 0.
- `rgb`  out  6  registered RGB222 pixel.
- `hsync_out`  out  1  `hsync_in` delayed to align with `rgb`.
- `vsync_out`  out  1  `vsync_in` delayed to align with `rgb`.
- `frame`  out  COUNTER_W  current frame counter.

## Operation
- Frame counter:
  - `vsync_q` registers `vsync_in`; frame edge = `vsync_in & ~vsync_q`. This is a clk-domain edge detect; vsync is never used as a clock.
  - On the edge, the counter advances by ±1 (per `dir`) if `run`=1, or if `step_pending`=1.
  - `step_pending` sets on any cycle where `step`=1 and `run`=0. It clears when consumed.
  - Step and edge in the same cycle: the step is consumed on that edge.
  - Wraps modulo 2^COUNTER_W in both directions.
- Layer i offsets, all truncated to COORD_W:
  - x_i = `hpos` + (`frame` << (NUM_LAYERS-1-i)).
  - y_i = `vpos` + (`frame` >> i).
- Layer i hit = x_i[COORD_W-2-i] ^ y_i[COORD_W-2-i]. Bit index is clamped to ≥0.
- Colours:
  - layer 0 = `fg_color`.
  - layer 1 = `fg_color` ^ 6'b00_10_10.
  - layer 2 = 6'b10_00_00.
  - layers ≥3 = 6'b01_00_00.
- Priority: the lowest-index hit wins. No hit → 0.
- Blanking: `rgb` = 0 when the aligned `display_on` is 0.

## Timing
- Latency is 2 clk from `hpos`/`vpos`/`display_on`/`hsync_in`/`vsync_in` to `rgb`/`hsync_out`/`vsync_out`.
  - Stage 1: register the per-layer hit bits plus the delayed flags.
  - Stage 2: priority mux into `rgb`, plus the delayed syncs.
- `frame` updates on the clock edge where the frame edge is detected. It is visible the following cycle.
- Reset (any cycle, including mid-frame): `frame`=0, `vsync_q`=0, `step_pending`=0, `rgb`=0, `hsync_out`=0, `vsync_out`=0, pipeline flags=0.
- If `vsync_in` is high when reset deasserts, no edge is counted until the next rising edge.

## Configuration
- `CHECKER_DITHER_EN` defined: hits are gated by stipple patterns.
  - Layer 0 by (`vpos`[1]^`hpos`[0]).
  - Layer 1 by (~`vpos`[0]^`hpos`[1]).
  - Layer NUM_LAYERS-1 (if ≥2) by (`vpos`[1]^`hpos`[0]).
  - A gated-off pixel falls through to lower-priority layers.
- Undefined: all layers solid; no gating logic is synthesised.
- Latency is identical in both builds.

## Structure
- Package `checker_pkg`:
  - RGB222 width constant (6).
  - Colour constants `COL_RED_HI`=6'b10_00_00, `COL_RED_LO`=6'b01_00_00, `GREY_XOR`=6'b00_10_10.
  - Function returning the layer colour given index and `fg_color`.
- Sub-module `checker_layer`: one instance per layer via generate.
  - Parameter `IDX`.
  - Computes offsets and the hit bit from `hpos`, `vpos`, `frame`.
- Top level holds the counter, step logic, pipeline and priority mux.

## Test plan
- Reset then hold `run`=1, `dir`=0; drive 3 vsync rising edges → `frame` = 1, 2, 3, each one cycle after its edge.
- `run`=0, pulse `step` once mid-frame → the next edge gives `frame` +1; the edge after that gives no change.
- `dir`=1 from `frame`=0, one edge → `frame` = 2^COUNTER_W-1 (1023).
- Default params, `frame`=0, `fg_color`=6'b11_11_11, pixel (256,0) → layer 0 hit; `rgb`=6'b11_11_11 exactly 2 cycles later, with `hsync_out` matching `hsync_in` delayed 2.
- `display_on`=0 at a layer-0 hit pixel → `rgb`=0 two cycles later.
- Assert `reset` mid-frame with `frame`=5 and `step_pending`=1 → all outputs 0 next cycle; with `vsync_in` held high after release, `frame` stays 0.
